// File: rtl/gates_arb_pkg.sv
// Shared types and constants for the gates arbiter: opcode and FSM state encodings.
package gates_arb_pkg;

   typedef enum logic [2:0] {
      OP_AND  = 3'd0,
      OP_OR   = 3'd1,
      OP_XOR  = 3'd2,
      OP_NAND = 3'd3,
      OP_NOR  = 3'd4
   } op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   // Highest legal opcode; anything above is flagged as an error.
   localparam logic [2:0] OP_LAST = 3'd4;

endpackage

// File: rtl/gates_arbiter_datapath.sv
// Single shared bitwise logic unit; produces all five results in parallel.
module gates_arbiter_datapath #(
   parameter int w = 2
) (
   input  logic [w-1:0] a,
   input  logic [w-1:0] b,
   output logic [w-1:0] y_and,
   output logic [w-1:0] y_or,
   output logic [w-1:0] y_xor,
   output logic [w-1:0] y_nand,
   output logic [w-1:0] y_nor
);

   assign y_and  = a & b;
   assign y_or   = a | b;
   assign y_xor  = a ^ b;
   assign y_nand = ~(a & b);
   assign y_nor  = ~(a | b);

endmodule

// File: rtl/gates_arbiter.sv
// Round-robin arbiter sharing one gates datapath between N requesters,
// one operation in flight, registered response tagged with the requester ID.
module gates_arbiter
   import gates_arb_pkg::*;
#(
   parameter int W = 2,
   parameter int N = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N-1:0]         req_valid,
   output logic [N-1:0]         req_ready,
   input  logic [N*3-1:0]       req_op,
   input  logic [N*W-1:0]       req_a,
   input  logic [N*W-1:0]       req_b,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [W-1:0]         rsp_data,
   output logic [$clog2(N)-1:0] rsp_id,
   output logic                 rsp_err,
   output logic                 busy
);

   localparam int IW = $clog2(N);

   state_t        state;
   state_t        state_next;
   logic [IW-1:0] rr_ptr;
   logic [IW-1:0] grant;
   logic          found;
   logic [2:0]    op_q;
   logic [W-1:0]  a_q;
   logic [W-1:0]  b_q;
   logic [IW-1:0] id_q;
   logic [W-1:0]  result;
   logic [W-1:0]  y_and, y_or, y_xor, y_nand, y_nor;

   logic [2:0]    ops [N];
   logic [W-1:0]  as  [N];
   logic [W-1:0]  bs  [N];

   for (genvar i = 0; i < N; i++) begin : g_slice
      assign ops[i] = req_op[3*i +: 3];
      assign as[i]  = req_a[W*i +: W];
      assign bs[i]  = req_b[W*i +: W];
   end

   // First valid requester at or after rr_ptr, wrapping N-1 -> 0.
   always_comb begin
      int            idx;
      logic [IW-1:0] cand;
      grant = '0;
      found = 1'b0;
      idx   = 0;
      cand  = '0;
      for (int k = 0; k < N; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= N) idx = idx - N;
         cand = IW'(idx);
         if (!found && req_valid[cand]) begin
            found = 1'b1;
            grant = cand;
         end
      end
   end

   always_comb begin
      state_next = state;
      req_ready  = '0;
      case (state)
         IDLE: begin
            if (found) begin
               req_ready[grant] = 1'b1;
               state_next       = EXEC;
            end
         end
         EXEC:    state_next = RESP;
         RESP:    if (rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   gates_arbiter_datapath #(.w(W)) u_datapath (
      .a      (a_q),
      .b      (b_q),
      .y_and  (y_and),
      .y_or   (y_or),
      .y_xor  (y_xor),
      .y_nand (y_nand),
      .y_nor  (y_nor)
   );

   always_comb begin
      result = '0;
      case (op_q)
         OP_AND:  result = y_and;
         OP_OR:   result = y_or;
         OP_XOR:  result = y_xor;
         OP_NAND: result = y_nand;
         OP_NOR:  result = y_nor;
         default: result = '0;
      endcase
   end

   // Operands latch on grant; the response registers load once in EXEC and then hold through RESP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         id_q     <= '0;
         rsp_data <= '0;
         rsp_id   <= '0;
         rsp_err  <= 1'b0;
      end else begin
         state <= state_next;
         if (state == IDLE && found) begin
            op_q   <= ops[grant];
            a_q    <= as[grant];
            b_q    <= bs[grant];
            id_q   <= grant;
            rr_ptr <= (grant == IW'(N-1)) ? '0 : grant + IW'(1);
         end
         if (state == EXEC) begin
            rsp_data <= result;
            rsp_id   <= id_q;
            rsp_err  <= (op_q > OP_LAST);
         end
      end
   end

   assign rsp_valid = (state == RESP);
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_gates_arbiter.sv
// Directed self-checking bench for gates_arbiter with a response scoreboard.
module tb_gates_arbiter;

   localparam int W  = 2;
   localparam int N  = 4;
   localparam int IW = 2;

   typedef struct packed {
      logic [IW-1:0] id;
      logic [W-1:0]  data;
      logic          err;
   } rsp_t;

   logic            clk;
   logic            rst_n;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N*3-1:0]  req_op;
   logic [N*W-1:0]  req_a;
   logic [N*W-1:0]  req_b;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [W-1:0]    rsp_data;
   logic [IW-1:0]   rsp_id;
   logic            rsp_err;
   logic            busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int lastAcceptCyc = -1;
   int acceptCount = 0;
   logic checkInterval = 1'b0;
   logic [N-1:0] holdMask = '0;

   rsp_t rspQ[$];
   int   expGrantQ[$];

   logic [N-1:0]  smpReady;
   logic          smpBusy;
   logic          smpValid;
   logic [W-1:0]  smpData;
   logic [IW-1:0] smpId;
   logic          smpErr;
   logic [W-1:0]  lastRspData;
   logic          lastRspErr;

   logic [2:0] opList [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6};
   logic [1:0] opExp  [6] = '{2'b10, 2'b11, 2'b01, 2'b01, 2'b00, 2'b00};

   gates_arbiter #(.W(W), .N(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id),
      .rsp_err   (rsp_err),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop if the directed sequence ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic rsp_t model(input int id, input logic [2:0] op,
                                  input logic [W-1:0] a, input logic [W-1:0] b);
      rsp_t r;
      r.id   = IW'(id);
      r.err  = 1'b0;
      case (op)
         3'd0:    r.data = a & b;
         3'd1:    r.data = a | b;
         3'd2:    r.data = a ^ b;
         3'd3:    r.data = ~(a & b);
         3'd4:    r.data = ~(a | b);
         default: begin r.data = '0; r.err = 1'b1; end
      endcase
      return r;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
         $error("[TB] %s check failed", tag);
      end
   endtask

   task automatic applyStimulus(input int i, input logic [2:0] op,
                                input logic [W-1:0] a, input logic [W-1:0] b);
      req_op[3*i +: 3] = op;
      req_a[W*i +: W]  = a;
      req_b[W*i +: W]  = b;
      req_valid[i]     = 1'b1;
   endtask

   // One clock: sample at negedge, score accepts and responses, then release accepted requesters.
   task automatic tick();
      int   g;
      int   expId;
      rsp_t e;
      rsp_t got;
      g = -1;
      @(negedge clk);
      cyc++;
      smpReady = req_ready;
      smpBusy  = busy;
      smpValid = rsp_valid;
      smpData  = rsp_data;
      smpId    = rsp_id;
      smpErr   = rsp_err;
      if (req_ready != '0) begin
         checkOutput("ready_onehot", 32'($countones(req_ready)), 32'd1);
         for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
         checkOutput("ready_has_valid", 32'(req_valid[g]), 32'd1);
         expId = g;
         if (expGrantQ.size() > 0) begin
            expId = expGrantQ.pop_front();
            checkOutput("grant_id", 32'(g), 32'(expId));
         end
         e = model(expId, req_op[3*g +: 3], req_a[W*g +: W], req_b[W*g +: W]);
         rspQ.push_back(e);
         if (checkInterval && lastAcceptCyc >= 0)
            checkOutput("accept_interval", 32'(cyc - lastAcceptCyc), 32'd3);
         lastAcceptCyc = cyc;
         acceptCount++;
      end
      if (rsp_valid && rsp_ready) begin
         if (rspQ.size() == 0) begin
            checkOutput("rsp_unexpected", 32'd1, 32'd0);
         end else begin
            e   = rspQ.pop_front();
            got = '{id: rsp_id, data: rsp_data, err: rsp_err};
            checkOutput("rsp_data", 32'(got.data), 32'(e.data));
            checkOutput("rsp_id", 32'(got.id), 32'(e.id));
            checkOutput("rsp_err", 32'(got.err), 32'(e.err));
            lastRspData = got.data;
            lastRspErr  = got.err;
         end
      end
      @(posedge clk);
      #1;
      if (g >= 0 && !holdMask[g]) req_valid[g] = 1'b0;
   endtask

   task automatic runTxn(input int maxCyc);
      for (int c = 0; c < maxCyc; c++) begin
         tick();
         if (req_valid == '0 && rspQ.size() == 0) return;
      end
      checkOutput("txn_timeout", 32'd1, 32'd0);
   endtask

   task automatic applyReset();
      req_valid = '0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      rspQ.delete();
      expGrantQ.delete();
      lastAcceptCyc = -1;
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = '0;
      req_op    = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b1;

      // Reset state
      tick();
      checkOutput("rst_rsp_valid", 32'(smpValid), 32'd0);
      checkOutput("rst_busy", 32'(smpBusy), 32'd0);
      checkOutput("rst_req_ready", 32'(smpReady), 32'd0);
      checkOutput("rst_rsp_data", 32'(smpData), 32'd0);
      checkOutput("rst_rsp_id", 32'(smpId), 32'd0);
      checkOutput("rst_rsp_err", 32'(smpErr), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single request with cycle-exact latency
      applyStimulus(1, 3'd0, 2'b11, 2'b10);
      expGrantQ.push_back(1);
      tick();
      checkOutput("c0_req_ready", 32'(smpReady), 32'b0010);
      checkOutput("c0_busy", 32'(smpBusy), 32'd0);
      tick();
      checkOutput("c1_busy", 32'(smpBusy), 32'd1);
      checkOutput("c1_rsp_valid", 32'(smpValid), 32'd0);
      checkOutput("c1_req_ready", 32'(smpReady), 32'd0);
      tick();
      checkOutput("c2_busy", 32'(smpBusy), 32'd1);
      checkOutput("c2_rsp_valid", 32'(smpValid), 32'd1);
      checkOutput("c2_rsp_data", 32'(smpData), 32'b10);
      checkOutput("c2_rsp_id", 32'(smpId), 32'd1);
      tick();
      checkOutput("c3_busy", 32'(smpBusy), 32'd0);

      // Every opcode on a=10, b=11, plus one illegal opcode
      for (int k = 0; k < 6; k++) begin
         applyStimulus(0, opList[k], 2'b10, 2'b11);
         expGrantQ.push_back(0);
         runTxn(20);
         checkOutput("op_table_data", 32'(lastRspData), 32'(opExp[k]));
         checkOutput("op_table_err", 32'(lastRspErr), (k == 5) ? 32'd1 : 32'd0);
      end

      // Fairness: all requesters held high for 12 accepts
      applyReset();
      holdMask      = '1;
      checkInterval = 1'b1;
      acceptCount   = 0;
      for (int i = 0; i < N; i++) applyStimulus(i, 3'(i), 2'(i), 2'(3 - i));
      for (int r = 0; r < 3; r++)
         for (int i = 0; i < N; i++) expGrantQ.push_back(i);
      for (int c = 0; c < 60 && acceptCount < 12; c++) tick();
      checkOutput("fair_accepts", 32'(acceptCount), 32'd12);
      req_valid     = '0;
      holdMask      = '0;
      checkInterval = 1'b0;
      runTxn(10);

      // Backpressure: response held for five cycles with rsp_ready low
      applyStimulus(2, 3'd2, 2'b01, 2'b11);
      expGrantQ.push_back(2);
      tick();
      checkOutput("bp_accept", 32'(smpReady), 32'b0100);
      rsp_ready = 1'b0;
      applyStimulus(3, 3'd0, 2'b11, 2'b11);
      expGrantQ.push_back(3);
      tick();
      checkOutput("bp_exec_ready", 32'(smpReady), 32'd0);
      for (int c = 0; c < 5; c++) begin
         tick();
         checkOutput("bp_hold_valid", 32'(smpValid), 32'd1);
         checkOutput("bp_hold_data", 32'(smpData), 32'b10);
         checkOutput("bp_hold_id", 32'(smpId), 32'd2);
         checkOutput("bp_hold_ready", 32'(smpReady), 32'd0);
      end
      rsp_ready = 1'b1;
      tick();
      checkOutput("bp_handshake_ready", 32'(smpReady), 32'd0);
      tick();
      checkOutput("bp_resume_ready", 32'(smpReady), 32'b1000);
      runTxn(10);

      // Reset in EXEC discards the op and clears the pointer
      applyStimulus(0, 3'd1, 2'b01, 2'b10);
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("midrst_busy", 32'(busy), 32'd0);
      checkOutput("midrst_req_ready", 32'(req_ready), 32'd0);
      rspQ.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      lastAcceptCyc = -1;
      applyStimulus(2, 3'd3, 2'b10, 2'b10);
      applyStimulus(3, 3'd4, 2'b00, 2'b01);
      expGrantQ.push_back(2);
      expGrantQ.push_back(3);
      runTxn(20);

      // Wrap and skip: pointer at 3, only requesters 0 and 1 valid
      applyStimulus(2, 3'd2, 2'b11, 2'b01);
      expGrantQ.push_back(2);
      runTxn(10);
      applyStimulus(0, 3'd0, 2'b01, 2'b11);
      applyStimulus(1, 3'd1, 2'b10, 2'b00);
      expGrantQ.push_back(0);
      expGrantQ.push_back(1);
      runTxn(20);
      checkOutput("grants_consumed", 32'(expGrantQ.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
